serial_link_ddr_chan_tx: RTL and testbench

- Physical-layer transmitter for one serial-link channel.
- Consumes `phy_data_t` beats (2*NumLanes bits) over a valid/ready handshake from the data link layer.
- Serializes each beat onto NumLanes DDR wires: lower half of the beat, then upper half.
- Generates a forwarded source-synchronous clock for the receiving PHY. Its edges are placed by programmable phase-shift values inside a divided bit period.

---
 rtl/serial_link_pkg.sv | 18 +
 rtl/serial_link_ddr_clk_gen.sv | 81 ++++++++
 rtl/serial_link_ddr_chan_tx.sv | 102 ++++++++++
 tb/tb_serial_link_ddr_chan_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared types and constants for the serial-link PHY
// Holds the beat type (two DDR halves per lane), the divider width default
// and the transmitter FSM state encoding.
package serial_link_pkg;

    localparam int unsigned NumLanesDefault    = 8;
    localparam int unsigned ClkDivWidthDefault = 10;
    // One beat carries two bits per lane: lower half first, then upper half.
    localparam int unsigned PhyDataWidth       = 2 * NumLanesDefault;

    typedef logic [PhyDataWidth-1:0] phy_data_t;

    typedef enum logic {
        PhyTxIdle,
        PhyTxSend
    } phy_tx_state_e;

endpackage

// File: rtl/serial_link_ddr_clk_gen.sv
// rtl/serial_link_ddr_clk_gen.sv - bit-period counter and forwarded-clock generator
// Ports:
//   clk_i, rst_i            system clock, async active-high reset
//   load_i                  a beat is accepted this cycle: restart period, latch cfg
//   send_d_i                transmitter will be in SEND next cycle
//   cfg_clk_div_i           requested cycles per beat (rounded down to even, min 2)
//   cfg_clk_shift_start_i   counter value where the forwarded clock rises
//   cfg_clk_shift_end_i     counter value where the forwarded clock falls
//   eop_o                   current cycle is the last of the beat period
//   lo_half_d_o             next cycle is in the lower-half window of the beat
//   ddr_rcv_clk_o           registered forwarded clock
module serial_link_ddr_clk_gen
    import serial_link_pkg::*;
#(
    parameter int unsigned ClkDivWidth = ClkDivWidthDefault
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic                   send_d_i,
    input  logic [ClkDivWidth-1:0] cfg_clk_div_i,
    input  logic [ClkDivWidth-1:0] cfg_clk_shift_start_i,
    input  logic [ClkDivWidth-1:0] cfg_clk_shift_end_i,
    output logic                   eop_o,
    output logic                   lo_half_d_o,
    output logic                   ddr_rcv_clk_o
);

    localparam logic [ClkDivWidth-1:0] DivMin = ClkDivWidth'(2);
    localparam logic [ClkDivWidth-1:0] One    = ClkDivWidth'(1);

    logic [ClkDivWidth-1:0] cnt_q, cnt_d;
    logic [ClkDivWidth-1:0] div_q, div_d;
    logic [ClkDivWidth-1:0] start_q, start_d;
    logic [ClkDivWidth-1:0] end_q, end_d;
    logic                   fclk_q, fclk_d;
    logic [ClkDivWidth-1:0] div_even;
    logic [ClkDivWidth-1:0] div_eff;

    assign eop_o         = (cnt_q == div_q - One);
    assign ddr_rcv_clk_o = fclk_q;

    always_comb begin
        div_even = {cfg_clk_div_i[ClkDivWidth-1:1], 1'b0};
        div_eff  = (div_even < DivMin) ? DivMin : div_even;
        cnt_d    = cnt_q;
        div_d    = div_q;
        start_d  = start_q;
        end_d    = end_q;
        if (load_i) begin
            cnt_d   = '0;
            div_d   = div_eff;
            start_d = cfg_clk_shift_start_i;
            end_d   = cfg_clk_shift_end_i;
        end else if (send_d_i) begin
            cnt_d = cnt_q + One;
        end else begin
            cnt_d = '0;
        end
        // cnt never reaches div, so shift values at or beyond div clip naturally.
        fclk_d      = send_d_i && (cnt_d >= start_d) && (cnt_d < end_d);
        lo_half_d_o = (cnt_d < (div_d >> 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            div_q   <= DivMin;
            start_q <= '0;
            end_q   <= '0;
            fclk_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            start_q <= start_d;
            end_q   <= end_d;
            fclk_q  <= fclk_d;
        end
    end

endmodule

// File: rtl/serial_link_ddr_chan_tx.sv
// rtl/serial_link_ddr_chan_tx.sv - DDR physical-layer transmitter for one serial-link channel
// Ports:
//   clk_i, rst_i            system clock, async active-high reset
//   data_in_i/_valid_i      beat from the data link layer (2*NumLanes bits)
//   data_in_ready_o         beat accepted this cycle when valid is high
//   cfg_tx_en_i             allows new beats to be accepted
//   cfg_clk_div_i           cycles per beat
//   cfg_clk_shift_start_i   forwarded-clock rising-edge counter value
//   cfg_clk_shift_end_i     forwarded-clock falling-edge counter value
//   ddr_o                   lane data: lower half of beat, then upper half
//   ddr_rcv_clk_o           forwarded clock
//   busy_o                  high while a beat is on the wires
module serial_link_ddr_chan_tx
    import serial_link_pkg::*;
#(
    parameter int unsigned NumLanes    = NumLanesDefault,
    parameter int unsigned ClkDivWidth = ClkDivWidthDefault
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [2*NumLanes-1:0]   data_in_i,
    input  logic                    data_in_valid_i,
    output logic                    data_in_ready_o,
    input  logic                    cfg_tx_en_i,
    input  logic [ClkDivWidth-1:0]  cfg_clk_div_i,
    input  logic [ClkDivWidth-1:0]  cfg_clk_shift_start_i,
    input  logic [ClkDivWidth-1:0]  cfg_clk_shift_end_i,
    output logic [NumLanes-1:0]     ddr_o,
    output logic                    ddr_rcv_clk_o,
    output logic                    busy_o
);

    phy_tx_state_e           state_q, state_d;
    logic [2*NumLanes-1:0]   data_q, data_d;
    logic [NumLanes-1:0]     ddr_q, ddr_d;
    logic                    busy_q, busy_d;
    // Holds ready low for the first cycle after reset release.
    logic                    rdy_en_q;
    logic                    eop;
    logic                    lo_half_d;
    logic                    accept;

    assign data_in_ready_o = rdy_en_q && cfg_tx_en_i && ((state_q == PhyTxIdle) || eop);
    assign accept          = data_in_valid_i && data_in_ready_o;
    assign ddr_o           = ddr_q;
    assign busy_o          = busy_q;

    serial_link_ddr_clk_gen #(
        .ClkDivWidth (ClkDivWidth)
    ) u_clk_gen (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .load_i                (accept),
        .send_d_i              (state_d == PhyTxSend),
        .cfg_clk_div_i         (cfg_clk_div_i),
        .cfg_clk_shift_start_i (cfg_clk_shift_start_i),
        .cfg_clk_shift_end_i   (cfg_clk_shift_end_i),
        .eop_o                 (eop),
        .lo_half_d_o           (lo_half_d),
        .ddr_rcv_clk_o         (ddr_rcv_clk_o)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            PhyTxIdle: if (accept) state_d = PhyTxSend;
            PhyTxSend: if (eop)    state_d = accept ? PhyTxSend : PhyTxIdle;
            default:               state_d = PhyTxIdle;
        endcase
        data_d = accept ? data_in_i : data_q;
        busy_d = (state_d == PhyTxSend);
        // Lane data is registered from next-state values so it lines up with cnt.
        if (state_d == PhyTxSend) begin
            ddr_d = lo_half_d ? data_d[NumLanes-1:0] : data_d[2*NumLanes-1:NumLanes];
        end else begin
            ddr_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= PhyTxIdle;
            data_q   <= '0;
            ddr_q    <= '0;
            busy_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            ddr_q    <= ddr_d;
            busy_q   <= busy_d;
            rdy_en_q <= 1'b1;
        end
    end

    a_data_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (data_in_valid_i && !data_in_ready_o) |=> $stable(data_in_i));

    a_no_ready_in_reset : assert property (@(posedge clk_i)
        rst_i |-> !data_in_ready_o);

endmodule

// File: tb/tb_serial_link_ddr_chan_tx.sv
// tb/tb_serial_link_ddr_chan_tx.sv - directed self-checking bench for serial_link_ddr_chan_tx
module tb_serial_link_ddr_chan_tx;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        valid;
    logic        ready;
    logic        en;
    logic [9:0]  cfg_div;
    logic [9:0]  cfg_start;
    logic [9:0]  cfg_end;
    logic [7:0]  ddr;
    logic        rcv_clk;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    serial_link_ddr_chan_tx #(
        .NumLanes    (8),
        .ClkDivWidth (10)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .data_in_i             (data_in),
        .data_in_valid_i       (valid),
        .data_in_ready_o       (ready),
        .cfg_tx_en_i           (en),
        .cfg_clk_div_i         (cfg_div),
        .cfg_clk_shift_start_i (cfg_start),
        .cfg_clk_shift_end_i   (cfg_end),
        .ddr_o                 (ddr),
        .ddr_rcv_clk_o         (rcv_clk),
        .busy_o                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat from IDLE; t is cycles after the accept cycle t0.
    task automatic run_beat(input string tag, input logic [15:0] data, input logic [9:0] raw_div,
                            input int div, input int s, input int e, input int drop_en_at);
        logic [7:0] exp_ddr;
        logic       exp_clk;
        logic       exp_busy;
        int         k;
        cfg_div   = raw_div;
        cfg_start = 10'(s);
        cfg_end   = 10'(e);
        data_in   = data;
        valid     = 1'b1;
        #1;
        check({tag, "_ready_t0"}, 32'(ready), 32'(1));
        for (int t = 1; t <= div + 1; t++) begin
            tick();
            if (t == 1) valid = 1'b0;
            if (drop_en_at != 0 && t == drop_en_at) en = 1'b0;
            #1;
            k = t - 1;
            if (t <= div) begin
                exp_ddr  = (k < div / 2) ? data[7:0] : data[15:8];
                exp_clk  = (k >= s) && (k < e);
                exp_busy = 1'b1;
            end else begin
                exp_ddr  = 8'h00;
                exp_clk  = 1'b0;
                exp_busy = 1'b0;
            end
            check($sformatf("%s_ddr_t%0d", tag, t), 32'(ddr), 32'(exp_ddr));
            check($sformatf("%s_clk_t%0d", tag, t), 32'(rcv_clk), 32'(exp_clk));
            check($sformatf("%s_busy_t%0d", tag, t), 32'(busy), 32'(exp_busy));
            check($sformatf("%s_ready_t%0d", tag, t), 32'(ready), 32'(en && (t >= div)));
        end
    endtask

    initial begin
        logic [7:0] exp_ddr;
        int         b;
        int         k;

        rst       = 1'b1;
        data_in   = 16'h0000;
        valid     = 1'b0;
        en        = 1'b1;
        cfg_div   = 10'd8;
        cfg_start = 10'd2;
        cfg_end   = 10'd6;

        // Reset state
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'(0));
        check("rst_ddr", 32'(ddr), 32'(0));
        check("rst_clk", 32'(rcv_clk), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(ready), 32'(0));
        tick();
        check("idle_ready", 32'(ready), 32'(1));
        check("idle_busy", 32'(busy), 32'(0));

        // Single beat
        run_beat("single", 16'hA55A, 10'd8, 8, 2, 6, 0);

        // Three back-to-back beats
        data_in = 16'h1111;
        valid   = 1'b1;
        #1;
        check("b2b_ready_t0", 32'(ready), 32'(1));
        for (int t = 1; t <= 25; t++) begin
            tick();
            if (t == 1)  data_in = 16'h2222;
            if (t == 9)  data_in = 16'h3333;
            if (t == 17) valid = 1'b0;
            #1;
            b = (t - 1) / 8;
            k = (t - 1) % 8;
            exp_ddr = (b == 0) ? 8'h11 : (b == 1) ? 8'h22 : 8'h33;
            if (t > 24) exp_ddr = 8'h00;
            check($sformatf("b2b_ddr_t%0d", t), 32'(ddr), 32'(exp_ddr));
            check($sformatf("b2b_clk_t%0d", t), 32'(rcv_clk), 32'((t <= 24) && k >= 2 && k < 6));
            check($sformatf("b2b_busy_t%0d", t), 32'(busy), 32'(t <= 24));
            check($sformatf("b2b_ready_t%0d", t), 32'(ready), 32'((t % 8 == 0) || t == 25));
        end

        // Divider changed mid-beat: takes effect on the next beat only
        data_in = 16'hC33C;
        valid   = 1'b1;
        #1;
        check("divchg_ready_t0", 32'(ready), 32'(1));
        for (int t = 1; t <= 13; t++) begin
            tick();
            if (t == 1) data_in = 16'h9669;
            if (t == 3) cfg_div = 10'd4;
            if (t == 9) valid = 1'b0;
            #1;
            if (t <= 8) begin
                k = t - 1;
                check($sformatf("divchg_ddr_t%0d", t), 32'(ddr), 32'((k < 4) ? 8'h3C : 8'hC3));
                check($sformatf("divchg_clk_t%0d", t), 32'(rcv_clk), 32'(k >= 2 && k < 6));
                check($sformatf("divchg_busy_t%0d", t), 32'(busy), 32'(1));
            end else if (t <= 12) begin
                k = t - 9;
                check($sformatf("divchg_ddr_t%0d", t), 32'(ddr), 32'((k < 2) ? 8'h69 : 8'h96));
                check($sformatf("divchg_clk_t%0d", t), 32'(rcv_clk), 32'(k >= 2));
                check($sformatf("divchg_busy_t%0d", t), 32'(busy), 32'(1));
            end else begin
                check("divchg_ddr_end", 32'(ddr), 32'(0));
                check("divchg_busy_end", 32'(busy), 32'(0));
            end
            check($sformatf("divchg_ready_t%0d", t), 32'(ready), 32'(t == 8 || t == 12 || t == 13));
        end

        // Degenerate configurations
        run_beat("div3", 16'h7788, 10'd3, 2, 2, 6, 0);
        run_beat("div0", 16'h1234, 10'd0, 2, 2, 6, 0);
        run_beat("clk_flat", 16'h00FF, 10'd8, 8, 1, 1, 0);
        run_beat("clk_clip", 16'h3CA5, 10'd8, 8, 2, 12, 0);

        // Reset asserted mid-beat
        cfg_start = 10'd2;
        cfg_end   = 10'd6;
        data_in   = 16'h4321;
        valid     = 1'b1;
        #1;
        tick();
        valid = 1'b0;
        tick();
        tick();
        tick();
        check("midrst_pre_ddr", 32'(ddr), 32'(8'h21));
        check("midrst_pre_clk", 32'(rcv_clk), 32'(1));
        rst = 1'b1;
        #1;
        check("midrst_ddr", 32'(ddr), 32'(0));
        check("midrst_clk", 32'(rcv_clk), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_ready", 32'(ready), 32'(0));
        tick();
        check("midrst_hold_busy", 32'(busy), 32'(0));
        check("midrst_hold_ready", 32'(ready), 32'(0));
        rst = 1'b0;
        #1;
        check("midrst_rel_ready", 32'(ready), 32'(0));
        check("midrst_rel_busy", 32'(busy), 32'(0));
        tick();
        check("midrst_idle_ready", 32'(ready), 32'(1));
        run_beat("after_rst", 16'hBEEF, 10'd8, 8, 2, 6, 0);

        // Transmitter disabled with valid high
        en      = 1'b0;
        data_in = 16'hDEAD;
        valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("dis_ready_%0d", i), 32'(ready), 32'(0));
            check($sformatf("dis_busy_%0d", i), 32'(busy), 32'(0));
            check($sformatf("dis_ddr_%0d", i), 32'(ddr), 32'(0));
            tick();
        end
        en = 1'b1;
        run_beat("en_drop", 16'hDEAD, 10'd8, 8, 2, 6, 2);
        tick();
        check("en_drop_idle_busy", 32'(busy), 32'(0));
        check("en_drop_idle_ready", 32'(ready), 32'(0));
        check("en_drop_idle_ddr", 32'(ddr), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
